// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and boot status of the loader.
// The loader attaches through the slave modport; the image source/memory side uses master.
interface imem_boot_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_rst;
  logic        done;
  logic        err;

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, core_rst, done, err
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, core_rst, done, err
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a counted, XOR-checksummed byte frame into little-endian words,
// writes them to instruction memory and releases the core only after a verified load.
module imem_boot_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  imem_boot_loader_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH + 1);

  localparam logic [2:0] S_HDR_LO = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [7:0]       xor_q, xor_d;
  logic [23:0]      word_q, word_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;

  logic in_ready_w;
  logic accept;

  assign in_ready_w = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
  assign accept     = bus.in_valid && in_ready_w;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    xor_d     = xor_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_HDR_LO: if (accept) begin
        cnt_d[7:0] = bus.in_data;
        state_d    = S_HDR_HI;
      end
      S_HDR_HI: if (accept) begin
        cnt_d[15:8] = bus.in_data;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        if (cnt_q == 16'd0 || 32'(cnt_q) > DEPTH) begin
          state_d = S_ERR;
        end else begin
          idx_d   = '0;
          lane_d  = 2'd0;
          xor_d   = 8'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: if (accept) begin
        xor_d  = xor_q ^ bus.in_data;
        lane_d = lane_q + 2'd1;
        case (lane_q)
          2'd0: word_d[7:0]   = bus.in_data;
          2'd1: word_d[15:8]  = bus.in_data;
          2'd2: word_d[23:16] = bus.in_data;
          default: begin
            // Word complete: the write strobe lands in the next cycle with stable addr/data.
            wr_en_d   = 1'b1;
            wr_data_d = {bus.in_data, word_q};
            wr_addr_d = ADDR_BASE + (32'(idx_q) << 2);
            idx_d     = idx_q + IDX_W'(1);
            if (32'(idx_q) + 32'd1 == 32'(cnt_q)) state_d = S_CSUM;
          end
        endcase
      end
      S_CSUM: if (accept) begin
        state_d = (bus.in_data == xor_q) ? S_DONE : S_ERR;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HDR_LO;
      cnt_q     <= 16'd0;
      idx_q     <= '0;
      lane_q    <= 2'd0;
      xor_q     <= 8'd0;
      word_q    <= 24'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= ADDR_BASE;
      wr_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      xor_q     <= xor_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = (state_q == S_ERR);
  assign bus.core_rst = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: writes are checked against a scoreboard queue
// filled as frames are sent; status outputs are checked at fixed points.
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_boot_loader_if bus();

  imem_boot_loader #(.DEPTH(64), .ADDR_BASE(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          wr_cnt   = 0;
  logic [31:0] last_addr = '0;
  logic [63:0] exp_q[$];
  logic [31:0] img[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      last_addr = bus.wr_addr;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%0h_%0h expected=none", bus.wr_addr, bus.wr_data);
      end
      if (exp_q.size() > 0) chk("write_addr_data", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waitc;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    waitc = 0;
    while (bus.in_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (bus.in_ready !== 1'b1) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gaps, input bit bad_csum);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] n16;
    cs  = 8'd0;
    n16 = 16'(n);
    send_byte(n16[7:0], gaps);
    send_byte(n16[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      exp_q.push_back({32'(4 * i), w});
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], gaps);
        cs = cs ^ w[8*k +: 8];
      end
    end
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, gaps);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_cnt = 0;
    exp_q.delete();
  endtask

  task automatic header_err(input logic [7:0] lo, input logic [7:0] hi, input string tag);
    do_reset();
    send_byte(lo, 1'b0);
    send_byte(hi, 1'b0);
    chk({tag, "_check_err"}, 64'(bus.err), 64'd0);
    chk({tag, "_check_ready"}, 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_err"}, 64'(bus.err), 64'd1);
    chk({tag, "_core_rst"}, 64'(bus.core_rst), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_no_writes"}, 64'(wr_cnt), 64'd0);
  endtask

  task automatic check_queue_drained(input string tag);
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_core_rst", 64'(bus.core_rst), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Good load: 02 00 93 00 50 00 13 01 A0 00 71
    img = '{32'h0050_0093, 32'h00A0_0113};
    send_frame(2, 1'b0, 1'b0);
    chk("good_done", 64'(bus.done), 64'd1);
    chk("good_core_rst", 64'(bus.core_rst), 64'd0);
    chk("good_err", 64'(bus.err), 64'd0);
    chk("good_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) @(negedge clk);
    chk("good_wr_cnt", 64'(wr_cnt), 64'd2);
    check_queue_drained("good_queue");

    // Post-done input is ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (6) @(negedge clk);
    chk("post_done_ready", 64'(bus.in_ready), 64'd0);
    chk("post_done_done", 64'(bus.done), 64'd1);
    chk("post_done_wr_cnt", 64'(wr_cnt), 64'd2);
    bus.in_valid = 1'b0;

    // Bad checksum (0x70)
    do_reset();
    send_frame(2, 1'b0, 1'b1);
    chk("badcs_err", 64'(bus.err), 64'd1);
    chk("badcs_core_rst", 64'(bus.core_rst), 64'd1);
    chk("badcs_done", 64'(bus.done), 64'd0);
    chk("badcs_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) @(negedge clk);
    chk("badcs_wr_cnt", 64'(wr_cnt), 64'd2);

    // Count limits
    header_err(8'h00, 8'h00, "cnt_zero");
    header_err(8'h41, 8'h00, "cnt_over");

    do_reset();
    img.delete();
    for (int i = 0; i < 64; i++) img.push_back($urandom);
    send_frame(64, 1'b0, 1'b0);
    chk("full_done", 64'(bus.done), 64'd1);
    repeat (2) @(negedge clk);
    chk("full_wr_cnt", 64'(wr_cnt), 64'd64);
    chk("full_last_addr", 64'(last_addr), 64'h0000_00FC);
    check_queue_drained("full_queue");

    // Backpressure / gaps
    do_reset();
    img = '{32'h0050_0093, 32'h00A0_0113};
    send_frame(2, 1'b1, 1'b0);
    chk("gaps_done", 64'(bus.done), 64'd1);
    repeat (2) @(negedge clk);
    chk("gaps_wr_cnt", 64'(wr_cnt), 64'd2);
    check_queue_drained("gaps_queue");

    // Reset mid-load after 6 payload bytes, with a byte offered during rst
    do_reset();
    exp_q.push_back({32'h0, 32'h0050_0093});
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h01, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wr_en0", 64'(bus.wr_en), 64'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_wr_en1", 64'(bus.wr_en), 64'd0);
    chk("midrst_core_rst", 64'(bus.core_rst), 64'd1);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check_queue_drained("midrst_first_word");
    wr_cnt = 0;
    send_frame(2, 1'b0, 1'b0);
    chk("midrst_done", 64'(bus.done), 64'd1);
    repeat (2) @(negedge clk);
    chk("midrst_wr_cnt", 64'(wr_cnt), 64'd2);
    check_queue_drained("midrst_queue");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
